// File: rtl/mult_ctrl_sequencer.sv
// State register and next-state logic for the 4x4 shift-add multiplier controller.
// Optional START_EDGE_EN: a held start launches only one multiplication.
module mult_ctrl_sequencer #(
  parameter int ITERS = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_sel,
  output logic [2:0]       ps,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic             state_err
);

  // Codes are shared with the downstream control-signal decoder.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_INIT  = 3'b001,
    S_LOAD  = 3'b010,
    S_OP_11 = 3'b011,
    S_OP_01 = 3'b100,
    S_OP_10 = 3'b101,
    S_OP_00 = 3'b110
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  // Held as plain bits so the illegal code stays representable.
  logic [2:0]       ps_q, ps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             launch;

  function automatic logic [2:0] op_target(input logic [1:0] sel);
    case (sel)
      2'b00:   op_target = S_OP_00;
      2'b01:   op_target = S_OP_01;
      2'b10:   op_target = S_OP_10;
      default: op_target = S_OP_11;
    endcase
  endfunction

`ifdef START_EDGE_EN
  logic arm_q, arm_d;

  assign launch = start & arm_q;

  always_comb begin
    arm_d = arm_q;
    if (!start)
      arm_d = 1'b1;
    else if (ps_q == S_IDLE && launch)
      arm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arm_q <= 1'b1;
    else        arm_q <= arm_d;
  end
`else
  assign launch = start;
`endif

  always_comb begin
    ps_d   = ps_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (ps_q)
      S_IDLE: if (launch) ps_d = S_INIT;
      S_INIT: begin
        ps_d  = S_LOAD;
        cnt_d = '0;
      end
      S_LOAD: ps_d = op_target(op_sel);
      S_OP_11, S_OP_01, S_OP_10, S_OP_00: begin
        if (cnt_q == LAST) begin
          ps_d   = S_IDLE;
          done_d = 1'b1;
          cnt_d  = '0;
        end else begin
          ps_d  = op_target(op_sel);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        ps_d  = S_IDLE;
        err_d = 1'b1;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= S_IDLE;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign ps        = ps_q;
  assign busy      = (ps_q != S_IDLE);
  assign done      = done_q;
  assign cnt       = cnt_q;
  assign state_err = err_q;

endmodule

// File: tb/tb_mult_ctrl_sequencer.sv
// Self-checking bench for mult_ctrl_sequencer: directed scenarios plus random
// start/op_sel traffic against a phase-counting reference model.
module tb_mult_ctrl_sequencer;
  localparam int ITERS = 2;
  localparam int CNT_W = 2;
`ifdef START_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op_sel = 2'b00;
  logic [2:0]       ps;
  logic             busy, done, state_err;
  logic [CNT_W-1:0] cnt;

  mult_ctrl_sequencer #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
    .ps(ps), .busy(busy), .done(done), .cnt(cnt), .state_err(state_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Model: phase 0 idle, 1 init, 2 load, 3+k is the k-th operate step.
  int m_phase, m_ps, m_cnt, m_done, m_err;
  bit m_armed, m_ill;

  function automatic int op_code(input int sel);
    case (sel)
      0:       return 6;
      1:       return 4;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ps"},   int'(ps),        m_ps);
    chk({tag, ".busy"}, int'(busy),      int'(m_ps != 0));
    chk({tag, ".done"}, int'(done),      m_done);
    chk({tag, ".cnt"},  int'(cnt),       m_cnt);
    chk({tag, ".err"},  int'(state_err), m_err);
  endtask

  task automatic model_reset();
    m_phase = 0; m_ps = 0; m_cnt = 0; m_done = 0; m_err = 0;
    m_armed = 1'b1; m_ill = 1'b0;
  endtask

  task automatic model_edge(input bit s, input int sel);
    bit go;
    go = 1'b0;
    m_done = 0;
    m_err  = 0;
    if (m_ill) begin
      m_ill = 1'b0; m_phase = 0; m_ps = 0; m_cnt = 0; m_err = 1;
    end else if (m_phase == 0) begin
      go = s && (!EDGE || m_armed);
      if (go) begin m_phase = 1; m_ps = 1; end
    end else if (m_phase == 1) begin
      m_phase = 2; m_ps = 2; m_cnt = 0;
    end else if (m_phase == 2) begin
      m_phase = 3; m_ps = op_code(sel);
    end else if (m_phase - 3 == ITERS - 1) begin
      m_phase = 0; m_ps = 0; m_cnt = 0; m_done = 1;
    end else begin
      m_cnt = m_phase - 2; m_phase++; m_ps = op_code(sel);
    end
    if (!s) m_armed = 1'b1;
    else if (go) m_armed = 1'b0;
  endtask

  task automatic step(input bit s, input logic [1:0] sel, input string tag);
    @(negedge clk);
    start = s; op_sel = sel;
    @(posedge clk);
    model_edge(s, int'(sel));
    #1;
    check_all(tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_phase != 0; i++)
      step(1'b0, 2'($urandom), "drain");
    step(1'b0, 2'b00, "drain");
  endtask

  initial begin
    int first_op [4] = '{6, 4, 5, 3};
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom); op_sel = 2'($urandom);
      #1 check_all("reset");
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;

    // Normal run: expected ps 001,010,100,011,000 with done on the last
    step(1'b1, 2'b00, "run");  chk("run.ps1", int'(ps), 1);
    step(1'b0, 2'b10, "run");  chk("run.ps2", int'(ps), 2);
    step(1'b0, 2'b01, "run");  chk("run.ps3", int'(ps), 4); chk("run.cnt0", int'(cnt), 0);
    step(1'b0, 2'b11, "run");  chk("run.ps4", int'(ps), 3); chk("run.cnt1", int'(cnt), 1);
    step(1'b0, 2'b00, "run");  chk("run.ps5", int'(ps), 0); chk("run.done", int'(done), 1);
    step(1'b0, 2'b00, "run");  chk("run.done_clr", int'(done), 0);

    // Each op code held through the run selects its own first OP state
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 2'(s), "ops");
      step(1'b0, 2'(s), "ops");
      step(1'b0, 2'(s), "ops");
      chk("ops.first", int'(ps), first_op[s]);
      drain();
    end

    // Start held from launch through completion
    step(1'b1, 2'b01, "hold");
    for (int i = 0; i < ITERS + 2; i++) step(1'b1, 2'($urandom), "hold");
    chk("hold.done", int'(done), 1);
    step(1'b1, 2'b00, "hold");
    chk("hold.relaunch", int'(ps), EDGE ? 0 : 1);
`ifdef START_EDGE_EN
    step(1'b1, 2'b00, "hold");
    chk("hold.still_idle", int'(ps), 0);
    step(1'b0, 2'b00, "hold");
    step(1'b1, 2'b00, "hold");
    chk("hold.rearm", int'(ps), 1);
`endif
    drain();

    // Async reset while in OP_01
    step(1'b1, 2'b01, "areset");
    step(1'b0, 2'b01, "areset");
    step(1'b0, 2'b01, "areset");
    chk("areset.pre", int'(ps), 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset.now");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b10, "areset.after"); chk("areset.init", int'(ps), 1);
    drain();

    // Illegal code recovers to IDLE with a single error pulse
    force dut.ps_q = 3'b111;
    #1;
    release dut.ps_q;
    m_ill = 1'b1;
    step(1'b0, 2'b00, "illegal");
    chk("illegal.ps", int'(ps), 0);
    chk("illegal.err", int'(state_err), 1);
    chk("illegal.done", int'(done), 0);
    step(1'b0, 2'b00, "illegal");
    chk("illegal.err_clr", int'(state_err), 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0), 2'($urandom), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
